// File: rtl/uart_tx_fifo_drain_pkg.sv
// Shared definitions for the FIFO-draining UART transmitter: FSM encoding,
// data width and the parity helper. Parity is only used when UART_TX_PARITY_EN is defined.
package uart_tx_fifo_drain_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3,
    PARITY = 3'd4
  } state_t;

  function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_drain_bit_timer.sv
// Per-bit cycle counter: bit_end marks the last clock of a bit; clear restarts the count.
module uart_bit_timer #(
  parameter int BIT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_end
);

  localparam int CNT_W = $clog2(BIT_CYCLES);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  assign bit_end = (count_q == CNT_W'(BIT_CYCLES - 1));

  always_comb begin
    count_d = count_q + CNT_W'(1);
    if (clear || bit_end) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_tx_fifo_drain.sv
// UART 8N1 transmitter that pops one byte per frame from a FIFO and shifts it out LSB-first.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx_fifo_drain
  import uart_tx_fifo_drain_pkg::*;
#(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD_RATE = 9600
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fifo_empty,
  input  logic [DATA_BITS-1:0] fifo_pop_data,
  output logic                 fifo_pop,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int BIT_CYCLES = CLK_FREQ / BAUD_RATE;

  state_t               state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q, parity_d;
`endif
  logic                 bit_end;
  logic                 timer_clear;

  // Gated by rst so the FIFO is never popped while the transmitter is held in reset.
  assign fifo_pop    = rst & (state_q == IDLE) & ~fifo_empty;
  assign timer_clear = (state_q == IDLE) | bit_end;

  uart_bit_timer #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_bit_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (timer_clear),
    .bit_end(bit_end)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      IDLE: begin
        if (fifo_pop) begin
          shift_d   = fifo_pop_data;
          bit_idx_d = '0;
          tx_d      = 1'b0;
          busy_d    = 1'b1;
          state_d   = START;
`ifdef UART_TX_PARITY_EN
          parity_d  = even_parity(fifo_pop_data);
`endif
        end
      end
      START: begin
        if (bit_end) begin
          state_d   = DATA;
          bit_idx_d = '0;
          tx_d      = shift_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_idx_q == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
            tx_d    = parity_q;
`else
            state_d = STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = shift_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  assign tx      = tx_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Randomized bench for uart_tx_fifo_drain: a FIFO model feeds bytes and the expected line
// waveform is rebuilt from frame timing rules (start, data LSB-first, optional parity, stop).
module tb_uart_tx_fifo_drain;

  localparam int BITC = 16;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME  = NBITS * BITC;
  localparam int PERIOD = FRAME + 1;
  localparam int LOGN   = 16384;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       fifo_empty;
  logic [7:0] fifo_pop_data;
  logic       fifo_pop;
  logic       tx;
  logic       tx_busy;
  logic       tx_done;

  uart_tx_fifo_drain #(
    .CLK_FREQ (160),
    .BAUD_RATE(10)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .fifo_empty   (fifo_empty),
    .fifo_pop_data(fifo_pop_data),
    .fifo_pop     (fifo_pop),
    .tx           (tx),
    .tx_busy      (tx_busy),
    .tx_done      (tx_done)
  );

  always #5 clk = ~clk;

  // FIFO model feeding the DUT
  logic [7:0] fifo_mem [0:15];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int pop_count = 0;
  int cyc = 0;

  assign fifo_empty    = (rd_ptr == wr_ptr);
  assign fifo_pop_data = fifo_mem[rd_ptr[3:0]];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_pop) begin
      rd_ptr    <= rd_ptr + 1;
      pop_count <= pop_count + 1;
    end
  end

  // Per-cycle record of DUT outputs, sampled mid-cycle
  logic tx_log   [0:LOGN-1];
  logic pop_log  [0:LOGN-1];
  logic busy_log [0:LOGN-1];
  logic done_log [0:LOGN-1];

  always @(negedge clk) begin
    tx_log[cyc % LOGN]   <= tx;
    pop_log[cyc % LOGN]  <= fifo_pop;
    busy_log[cyc % LOGN] <= tx_busy;
    done_log[cyc % LOGN] <= tx_done;
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    fifo_mem[wr_ptr[3:0]] = b;
    wr_ptr++;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Line level of bit k within the frame for byte b
  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
`ifdef UART_TX_PARITY_EN
    if (k == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  // Frames start popping at cycle p0; each frame is FRAME clocks plus one idle clock.
  task automatic verify_window(input int p0, input logic [7:0] bq[$]);
    int n;
    int e_tx, e_pop, e_busy, e_done;
    int m_tx, m_pop, m_busy, m_done;
    n = bq.size();
    m_tx = 0; m_pop = 0; m_busy = 0; m_done = 0;
    for (int c = p0; c <= p0 + n * PERIOD + 8; c++) begin
      int rel, f, r;
      rel = c - p0;
      f = rel / PERIOD;
      r = rel % PERIOD;
      e_tx = 1; e_pop = 0; e_busy = 0; e_done = 0;
      if (rel > 0 && r == 0 && f <= n) e_done = 1;
      if (f < n) begin
        if (r == 0) e_pop = 1;
        else begin
          e_busy = 1;
          e_tx   = int'(frame_bit(bq[f], (r - 1) / BITC));
        end
      end
      if (int'(tx_log[c % LOGN])   != e_tx)   m_tx++;
      if (int'(pop_log[c % LOGN])  != e_pop)  m_pop++;
      if (int'(busy_log[c % LOGN]) != e_busy) m_busy++;
      if (int'(done_log[c % LOGN]) != e_done) m_done++;
    end
    for (int f = 0; f < n; f++)
      $display("frame byte=%02h pop_cycle=%0d", bq[f], p0 + f * PERIOD);
    check("tx_wave_mismatch_clocks", m_tx, 0);
    check("pop_mismatch_clocks", m_pop, 0);
    check("busy_mismatch_clocks", m_busy, 0);
    check("done_mismatch_clocks", m_done, 0);
  endtask

  // DUT must be idle at the call; pushes the bytes (unless preloaded) and checks the frames.
  task automatic run_frames(input logic [7:0] bq[$], input bit do_push);
    int p0, pc0;
    p0  = cyc;
    pc0 = pop_count;
    if (do_push) foreach (bq[i]) push(bq[i]);
    wait_cycles(bq.size() * PERIOD + 10);
    verify_window(p0, bq);
    check("pop_count", pop_count - pc0, bq.size());
  endtask

  initial begin
    logic [7:0] q[$];
    int c0, pc0, bad_tx, bad_busy, bad_pop;

    // Reset held with a byte waiting in the FIFO
    push(8'hA5);
    wait_cycles(3);
    check("reset_tx", tx, 1);
    check("reset_busy", tx_busy, 0);
    check("reset_done", tx_done, 0);
    check("reset_pop", fifo_pop, 0);

    // Release reset: the waiting 0xA5 goes out as the first frame
    rst = 1'b1;
    q.delete(); q.push_back(8'hA5);
    run_frames(q, 1'b0);

    // Back-to-back bytes
    q.delete(); q.push_back(8'h00); q.push_back(8'hFF); q.push_back(8'h55);
    run_frames(q, 1'b1);

    // Random batches with random idle gaps
    for (int b = 0; b < 4; b++) begin
      int n;
      n = $urandom_range(1, 3);
      q.delete();
      for (int i = 0; i < n; i++) q.push_back(8'($urandom));
      run_frames(q, 1'b1);
      wait_cycles($urandom_range(2, 20));
    end

`ifdef UART_TX_PARITY_EN
    q.delete(); q.push_back(8'h07);
    run_frames(q, 1'b1);
    q.delete(); q.push_back(8'h03);
    run_frames(q, 1'b1);
`endif

    // Reset in the middle of data bit 3 of 0x3C
    pc0 = pop_count;
    push(8'h3C);
    wait_cycles(1 + BITC * 4 + 5);
    #2;
    rst = 1'b0;
    #1;
    check("rst_async_tx", tx, 1);
    check("rst_async_busy", tx_busy, 0);
    check("rst_pops_before", pop_count - pc0, 1);
    $display("reset mid-frame byte=3c at cycle %0d", cyc);
    wait_cycles(2);
    rst = 1'b1;
    c0 = cyc;
    wait_cycles(50);
    bad_tx = 0; bad_busy = 0; bad_pop = 0;
    for (int c = c0; c < c0 + 49; c++) begin
      if (tx_log[c % LOGN] !== 1'b1) bad_tx++;
      if (busy_log[c % LOGN] !== 1'b0) bad_busy++;
      if (pop_log[c % LOGN] !== 1'b0) bad_pop++;
    end
    check("post_rst_tx_low_clocks", bad_tx, 0);
    check("post_rst_busy_clocks", bad_busy, 0);
    check("post_rst_pop_clocks", bad_pop, 0);

    // Empty FIFO for 1000 clocks
    pc0 = pop_count;
    c0 = cyc;
    wait_cycles(1000);
    bad_tx = 0; bad_busy = 0;
    for (int c = c0; c < c0 + 999; c++) begin
      if (tx_log[c % LOGN] !== 1'b1) bad_tx++;
      if (busy_log[c % LOGN] !== 1'b0) bad_busy++;
    end
    $display("idle window of 1000 clocks from cycle %0d", c0);
    check("empty_pops", pop_count - pc0, 0);
    check("empty_tx_low_clocks", bad_tx, 0);
    check("empty_busy_clocks", bad_busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
